// File: rtl/recompute_unit_os_pkg.sv
// rtl/recompute_unit_os_pkg.sv - shared types and helpers for the recompute unit
// Purpose: controller FSM state encoding and the mapping-field width helper.
package recompute_unit_os_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSIGN  = 3'd1,
    COMPUTE = 3'd2,
    PUBLISH = 3'd3,
    DONE    = 3'd4
  } ru_state_e;

  // Width of one row/column mapping field; never narrower than one bit.
  function automatic int cw_width(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

endpackage

// File: rtl/recompute_module.sv
// rtl/recompute_module.sv - NUM_RU spare MAC accumulators
// Purpose: per-RU multiply-accumulate with load-on-first-term and publish register.
// Ports:
//   clk, rst            clock, async active-low reset
//   ru_en               RU assigned
//   ru_top_inputs       top operand per RU slot
//   ru_left_inputs      left operand per RU slot
//   ru_set_stationary   load product instead of accumulating
//   ru_stat_bit_in      accumulate enable
//   ru_fsm_out_sel_in   publish accumulator to rcm_bottom_out
//   ru_col_mapping      target column tag (not used arithmetically)
//   rcm_bottom_out      published result per RU slot
module recompute_module
  import recompute_unit_os_pkg::*;
#(
  parameter int NUM_RU    = 4,
  parameter int WORD_SIZE = 16,
  parameter int COLS      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_RU-1:0]                 ru_en,
  input  logic [NUM_RU*WORD_SIZE-1:0]       ru_top_inputs,
  input  logic [NUM_RU*WORD_SIZE-1:0]       ru_left_inputs,
  input  logic [NUM_RU-1:0]                 ru_set_stationary,
  input  logic [NUM_RU-1:0]                 ru_stat_bit_in,
  input  logic [NUM_RU-1:0]                 ru_fsm_out_sel_in,
  input  logic [cw_width(COLS)*NUM_RU-1:0]  ru_col_mapping,
  output logic [NUM_RU*WORD_SIZE-1:0]       rcm_bottom_out
);

  logic [WORD_SIZE-1:0] acc  [NUM_RU];
  logic [WORD_SIZE-1:0] prod [NUM_RU];

  // The column tag travels with the RU for downstream bookkeeping only.
  logic unused_col_tag;
  assign unused_col_tag = ^ru_col_mapping;

  // Products truncate to WORD_SIZE bits (unsigned, modulo 2^WORD_SIZE).
  always_comb begin
    for (int i = 0; i < NUM_RU; i++) begin
      prod[i] = ru_left_inputs[i*WORD_SIZE +: WORD_SIZE] * ru_top_inputs[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RU; i++) begin
        acc[i] <= '0;
      end
      rcm_bottom_out <= '0;
    end else begin
      for (int i = 0; i < NUM_RU; i++) begin
        if (ru_en[i] && ru_stat_bit_in[i]) begin
          acc[i] <= ru_set_stationary[i] ? prod[i] : acc[i] + prod[i];
        end
        if (ru_en[i] && ru_fsm_out_sel_in[i]) begin
          rcm_bottom_out[i*WORD_SIZE +: WORD_SIZE] <= acc[i];
        end
      end
    end
  end

endmodule

// File: rtl/recompute_unit_controller_os.sv
// rtl/recompute_unit_controller_os.sv - fault-to-RU mapping FSM and operand streaming
// Purpose: latches the STW fault map, assigns the first NUM_RU faults (ascending
// index r*COLS+c) to RUs, then streams K operand pairs and a publish strobe.
// Ports:
//   clk, rst            clock, async active-low reset
//   top_matrix          element (k,c) at [(k*COLS+c)*WORD_SIZE +: WORD_SIZE]
//   left_matrix         element (r,k), same packing
//   STW_result_mat      bit r*COLS+c: 1 healthy, 0 faulty
//   ru_en               RU assigned
//   ru_top_inputs       top operand per RU slot
//   ru_left_inputs      left operand per RU slot
//   ru_set_stationary   first-term strobe
//   ru_stat_bit_in      accumulate enable
//   ru_fsm_out_sel_in   publish strobe
//   ru_col_mapping      target column per RU
//   ru_row_mapping      target row per RU
module recompute_unit_controller_os
  import recompute_unit_os_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int NUM_RU    = ROWS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]    top_matrix,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]    left_matrix,
  input  logic [ROWS*COLS-1:0]              STW_result_mat,
  output logic [NUM_RU-1:0]                 ru_en,
  output logic [NUM_RU*WORD_SIZE-1:0]       ru_top_inputs,
  output logic [NUM_RU*WORD_SIZE-1:0]       ru_left_inputs,
  output logic [NUM_RU-1:0]                 ru_set_stationary,
  output logic [NUM_RU-1:0]                 ru_stat_bit_in,
  output logic [NUM_RU-1:0]                 ru_fsm_out_sel_in,
  output logic [cw_width(COLS)*NUM_RU-1:0]  ru_col_mapping,
  output logic [cw_width(COLS)*NUM_RU-1:0]  ru_row_mapping
);

  localparam int CW = cw_width(COLS);
  localparam int NPE = ROWS * COLS;

  ru_state_e state, state_nxt;
  logic [CW-1:0]  k_cnt, k_nxt;
  logic [NPE-1:0] stw_map, map_nxt;

  logic [NUM_RU-1:0]           en_nxt, set_nxt, stat_nxt, sel_nxt;
  logic [NUM_RU*WORD_SIZE-1:0] top_nxt, left_nxt;
  logic [CW*NUM_RU-1:0]        row_nxt, col_nxt;

  // Priority encoder over the latched map.
  logic [NUM_RU-1:0]    scan_en;
  logic [CW*NUM_RU-1:0] scan_row, scan_col;
  int                   n_found;

  // Operand multiplexers for the current step k.
  logic [NUM_RU*WORD_SIZE-1:0] top_mux, left_mux;

  always_comb begin
    scan_en  = '0;
    scan_row = '0;
    scan_col = '0;
    n_found  = 0;
    for (int idx = 0; idx < NPE; idx++) begin
      if (!stw_map[idx]) begin
        // n_found is the rank of this fault; ranks >= NUM_RU match no RU.
        for (int j = 0; j < NUM_RU; j++) begin
          if (n_found == j) begin
            scan_en[j]             = 1'b1;
            scan_row[j*CW +: CW]   = CW'(idx / COLS);
            scan_col[j*CW +: CW]   = CW'(idx % COLS);
          end
        end
        n_found = n_found + 1;
      end
    end
  end

  // Select by comparing against every element position so all part-selects stay constant.
  always_comb begin
    top_mux  = '0;
    left_mux = '0;
    for (int i = 0; i < NUM_RU; i++) begin
      for (int e = 0; e < NPE; e++) begin
        if (ru_row_mapping[i*CW +: CW] == CW'(e / COLS) && k_cnt == CW'(e % COLS)) begin
          left_mux[i*WORD_SIZE +: WORD_SIZE] = left_matrix[e*WORD_SIZE +: WORD_SIZE];
        end
        if (k_cnt == CW'(e / COLS) && ru_col_mapping[i*CW +: CW] == CW'(e % COLS)) begin
          top_mux[i*WORD_SIZE +: WORD_SIZE] = top_matrix[e*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k_cnt;
    map_nxt   = stw_map;
    en_nxt    = ru_en;
    row_nxt   = ru_row_mapping;
    col_nxt   = ru_col_mapping;
    top_nxt   = '0;
    left_nxt  = '0;
    set_nxt   = '0;
    stat_nxt  = '0;
    sel_nxt   = '0;
    case (state)
      IDLE: begin
        if (!(&STW_result_mat)) begin
          map_nxt   = STW_result_mat;
          state_nxt = ASSIGN;
        end
      end
      ASSIGN: begin
        en_nxt    = scan_en;
        row_nxt   = scan_row;
        col_nxt   = scan_col;
        k_nxt     = '0;
        state_nxt = COMPUTE;
      end
      COMPUTE: begin
        for (int i = 0; i < NUM_RU; i++) begin
          if (ru_en[i]) begin
            top_nxt[i*WORD_SIZE +: WORD_SIZE]  = top_mux[i*WORD_SIZE +: WORD_SIZE];
            left_nxt[i*WORD_SIZE +: WORD_SIZE] = left_mux[i*WORD_SIZE +: WORD_SIZE];
          end
        end
        stat_nxt = ru_en;
        set_nxt  = (k_cnt == '0) ? ru_en : '0;
        if (k_cnt == CW'(COLS - 1)) begin
          state_nxt = PUBLISH;
        end else begin
          k_nxt = k_cnt + CW'(1);
        end
      end
      PUBLISH: begin
        sel_nxt   = ru_en;
        state_nxt = DONE;
      end
      DONE: begin
        // Map changes seen during a pass are only acted on here.
        if (STW_result_mat != stw_map) begin
          map_nxt = STW_result_mat;
          if (&STW_result_mat) begin
            en_nxt    = '0;
            row_nxt   = '0;
            col_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            state_nxt = ASSIGN;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      k_cnt             <= '0;
      stw_map           <= '0;
      ru_en             <= '0;
      ru_row_mapping    <= '0;
      ru_col_mapping    <= '0;
      ru_top_inputs     <= '0;
      ru_left_inputs    <= '0;
      ru_set_stationary <= '0;
      ru_stat_bit_in    <= '0;
      ru_fsm_out_sel_in <= '0;
    end else begin
      state             <= state_nxt;
      k_cnt             <= k_nxt;
      stw_map           <= map_nxt;
      ru_en             <= en_nxt;
      ru_row_mapping    <= row_nxt;
      ru_col_mapping    <= col_nxt;
      ru_top_inputs     <= top_nxt;
      ru_left_inputs    <= left_nxt;
      ru_set_stationary <= set_nxt;
      ru_stat_bit_in    <= stat_nxt;
      ru_fsm_out_sel_in <= sel_nxt;
    end
  end

endmodule

// File: rtl/recompute_unit_os.sv
// rtl/recompute_unit_os.sv - output-stationary fault-recovery recompute block
// Purpose: recomputes C(r,c) for PEs marked faulty by the STW using NUM_RU spare MACs.
// Ports:
//   clk, rst            clock, async active-low reset
//   top_matrix          element (k,c) at [(k*COLS+c)*WORD_SIZE +: WORD_SIZE]
//   left_matrix         element (r,k), same packing
//   STW_result_mat      bit r*COLS+c: 1 healthy, 0 faulty
//   ru_*                per-RU control/operand/mapping outputs
//   rcm_bottom_out      recomputed result per RU slot
module recompute_unit_os
  import recompute_unit_os_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int NUM_RU    = ROWS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]    top_matrix,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]    left_matrix,
  input  logic [ROWS*COLS-1:0]              STW_result_mat,
  output logic [NUM_RU-1:0]                 ru_en,
  output logic [NUM_RU*WORD_SIZE-1:0]       ru_top_inputs,
  output logic [NUM_RU*WORD_SIZE-1:0]       ru_left_inputs,
  output logic [NUM_RU-1:0]                 ru_set_stationary,
  output logic [NUM_RU-1:0]                 ru_stat_bit_in,
  output logic [NUM_RU-1:0]                 ru_fsm_out_sel_in,
  output logic [cw_width(COLS)*NUM_RU-1:0]  ru_col_mapping,
  output logic [cw_width(COLS)*NUM_RU-1:0]  ru_row_mapping,
  output logic [NUM_RU*WORD_SIZE-1:0]       rcm_bottom_out
);

  recompute_unit_controller_os #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .WORD_SIZE (WORD_SIZE),
    .NUM_RU    (NUM_RU)
  ) u_ctrl (
    .clk               (clk),
    .rst               (rst),
    .top_matrix        (top_matrix),
    .left_matrix       (left_matrix),
    .STW_result_mat    (STW_result_mat),
    .ru_en             (ru_en),
    .ru_top_inputs     (ru_top_inputs),
    .ru_left_inputs    (ru_left_inputs),
    .ru_set_stationary (ru_set_stationary),
    .ru_stat_bit_in    (ru_stat_bit_in),
    .ru_fsm_out_sel_in (ru_fsm_out_sel_in),
    .ru_col_mapping    (ru_col_mapping),
    .ru_row_mapping    (ru_row_mapping)
  );

  recompute_module #(
    .NUM_RU    (NUM_RU),
    .WORD_SIZE (WORD_SIZE),
    .COLS      (COLS)
  ) u_rcm (
    .clk               (clk),
    .rst               (rst),
    .ru_en             (ru_en),
    .ru_top_inputs     (ru_top_inputs),
    .ru_left_inputs    (ru_left_inputs),
    .ru_set_stationary (ru_set_stationary),
    .ru_stat_bit_in    (ru_stat_bit_in),
    .ru_fsm_out_sel_in (ru_fsm_out_sel_in),
    .ru_col_mapping    (ru_col_mapping),
    .rcm_bottom_out    (rcm_bottom_out)
  );

endmodule

// File: tb/tb_recompute_unit_os.sv
// tb/tb_recompute_unit_os.sv - self-checking bench for recompute_unit_os
module tb_recompute_unit_os;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int K  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [R*C*W-1:0] top_m, left_m;
  logic [R*C-1:0]   stw;

  logic [N-1:0]    ru_en, ru_set_stationary, ru_stat_bit_in, ru_fsm_out_sel_in;
  logic [N*W-1:0]  ru_top_inputs, ru_left_inputs, rcm_bottom_out;
  logic [N*CW-1:0] ru_col_mapping, ru_row_mapping;

  recompute_unit_os #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .NUM_RU(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .top_matrix        (top_m),
    .left_matrix       (left_m),
    .STW_result_mat    (stw),
    .ru_en             (ru_en),
    .ru_top_inputs     (ru_top_inputs),
    .ru_left_inputs    (ru_left_inputs),
    .ru_set_stationary (ru_set_stationary),
    .ru_stat_bit_in    (ru_stat_bit_in),
    .ru_fsm_out_sel_in (ru_fsm_out_sel_in),
    .ru_col_mapping    (ru_col_mapping),
    .ru_row_mapping    (ru_row_mapping),
    .rcm_bottom_out    (rcm_bottom_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] elem(input logic [R*C*W-1:0] m, input int a, input int b);
    return m[(a*C+b)*W +: W];
  endfunction

  function automatic logic [W-1:0] dot(input int r, input int c);
    longint unsigned s;
    s = 0;
    for (int k = 0; k < K; k++) begin
      s = s + longint'(elem(left_m, r, k)) * longint'(elem(top_m, k, c));
    end
    return s[W-1:0];
  endfunction

  // Behavioural model: a pass is a timeline measured in edges since the fault edge.
  int m_mode = 0;  // 0 idle, 1 pass in flight, 2 holding results
  int m_p = 0;
  logic [R*C-1:0] m_map = '0;
  int a_row [N];
  int a_col [N];
  int fq [$];
  logic [N-1:0]    x_en = '0, x_set = '0, x_stat = '0, x_sel = '0;
  logic [N*W-1:0]  x_top = '0, x_left = '0, x_rcm = '0;
  logic [N*CW-1:0] x_row = '0, x_col = '0;

  task automatic done_step();
    if (stw != m_map) begin
      m_map = stw;
      if (stw == '1) begin
        m_mode = 0;
        x_en = '0; x_row = '0; x_col = '0;
      end else begin
        m_mode = 1;
        m_p = 0;
      end
    end else begin
      m_mode = 2;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_p = 0; m_map = '0;
      x_en = '0; x_set = '0; x_stat = '0; x_sel = '0;
      x_top = '0; x_left = '0; x_rcm = '0; x_row = '0; x_col = '0;
    end else begin
      x_sel = '0;
      if (m_mode == 0) begin
        if (stw != '1) begin
          m_map = stw; m_mode = 1; m_p = 0;
        end
      end else if (m_mode == 1) begin
        m_p++;
        if (m_p == 1) begin
          fq.delete();
          for (int idx = 0; idx < R*C; idx++) if (!m_map[idx]) fq.push_back(idx);
          x_en = '0; x_row = '0; x_col = '0;
          for (int j = 0; j < N && j < fq.size(); j++) begin
            x_en[j] = 1'b1;
            a_row[j] = fq[j] / C;
            a_col[j] = fq[j] % C;
            x_row[j*CW +: CW] = CW'(a_row[j]);
            x_col[j*CW +: CW] = CW'(a_col[j]);
          end
        end else if (m_p <= 1 + K) begin
          x_top = '0; x_left = '0;
          for (int i = 0; i < N; i++) begin
            if (x_en[i]) begin
              x_left[i*W +: W] = elem(left_m, a_row[i], m_p - 2);
              x_top[i*W +: W]  = elem(top_m, m_p - 2, a_col[i]);
            end
          end
          x_stat = x_en;
          x_set  = (m_p == 2) ? x_en : '0;
        end else if (m_p == 2 + K) begin
          x_top = '0; x_left = '0; x_stat = '0; x_set = '0;
          x_sel = x_en;
        end else begin
          for (int i = 0; i < N; i++) if (x_en[i]) x_rcm[i*W +: W] = dot(a_row[i], a_col[i]);
          done_step();
        end
      end else begin
        done_step();
      end
    end
  end

  always @(negedge clk) begin
    chk("ru_en", 64'(ru_en), 64'(x_en));
    chk("ru_top_inputs", 64'(ru_top_inputs), 64'(x_top));
    chk("ru_left_inputs", 64'(ru_left_inputs), 64'(x_left));
    chk("ru_set_stationary", 64'(ru_set_stationary), 64'(x_set));
    chk("ru_stat_bit_in", 64'(ru_stat_bit_in), 64'(x_stat));
    chk("ru_fsm_out_sel_in", 64'(ru_fsm_out_sel_in), 64'(x_sel));
    chk("ru_row_mapping", 64'(ru_row_mapping), 64'(x_row));
    chk("ru_col_mapping", 64'(ru_col_mapping), 64'(x_col));
    chk("rcm_bottom_out", 64'(rcm_bottom_out), 64'(x_rcm));
  end

  int tp [16] = '{9, 4, 1, 5, 5, 12, 3, 2, 6, 8, 7, 1, 5, 3, 2, 7};
  int lp [16] = '{9, 4, 1, 5, 5, 12, 3, 2, 6, 8, 7, 4, 5, 3, 2, 7};
  int got;

  initial begin
    for (int i = 0; i < 16; i++) begin
      top_m[i*W +: W]  = W'(tp[i]);
      left_m[i*W +: W] = W'(lp[i]);
    end
    stw = '1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_en", 64'(ru_en), 64'h0);
    chk("reset_rcm", 64'(rcm_bottom_out), 64'h0);
    rst = 1'b1;

    // All healthy: nothing happens.
    repeat (5) @(negedge clk);
    chk("healthy_en", 64'(ru_en), 64'h0);
    chk("healthy_stat", 64'(ru_stat_bit_in), 64'h0);

    // Faults (0,1) and (1,1).
    stw = 16'b1111_1111_1101_1101;
    @(posedge clk);
    got = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        chk("assign_en", 64'(ru_en), 64'h3);
        chk("assign_row", 64'(ru_row_mapping), 64'h04);
        chk("assign_col", 64'(ru_col_mapping), 64'h05);
      end
      if (e == 2) begin
        chk("k0_left0", 64'(ru_left_inputs[15:0]), 64'd9);
        chk("k0_left1", 64'(ru_left_inputs[31:16]), 64'd5);
        chk("k0_top0", 64'(ru_top_inputs[15:0]), 64'd4);
        chk("k0_top1", 64'(ru_top_inputs[31:16]), 64'd4);
        chk("k0_set", 64'(ru_set_stationary), 64'h3);
      end
      if (got == 0 && rcm_bottom_out[15:0] == 16'd107) got = e;
    end
    chk("publish_latency", 64'(got), 64'd7);
    chk("result_slot0", 64'(rcm_bottom_out[15:0]), 64'd107);
    chk("result_slot1", 64'(rcm_bottom_out[31:16]), 64'd194);
    chk("result_slot23", 64'(rcm_bottom_out[63:32]), 64'd0);

    // Add fault (1,2): re-assign from the hold state.
    @(negedge clk);
    stw = 16'hFF9D;
    repeat (12) @(negedge clk);
    chk("reassign_en", 64'(ru_en), 64'h7);
    chk("reassign_slot2", 64'(rcm_bottom_out[47:32]), 64'd66);
    chk("reassign_slot0", 64'(rcm_bottom_out[15:0]), 64'd107);

    // Five faults: indices 0,3,5,10,15; index 15 is dropped.
    stw = 16'h7BD6;
    repeat (12) @(negedge clk);
    chk("five_en", 64'(ru_en), 64'hF);
    chk("five_row", 64'(ru_row_mapping), 64'h90);
    chk("five_col", 64'(ru_col_mapping), 64'h9C);

    // Reset in the middle of COMPUTE.
    stw = '1;
    repeat (4) @(negedge clk);
    stw = 16'hEFFE;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_en", 64'(ru_en), 64'h0);
    chk("midreset_left", 64'(ru_left_inputs), 64'h0);
    chk("midreset_rcm", 64'(rcm_bottom_out), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("restart_slot0", 64'(rcm_bottom_out[15:0]), 64'd132);
    chk("restart_slot1", 64'(rcm_bottom_out[31:16]), 64'd107);

    // Randomized maps and matrices; matrices change only while the model is idle.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        stw = '1;
        for (int w = 0; w < 20 && m_mode != 0; w++) @(negedge clk);
        for (int i = 0; i < R*C; i++) begin
          top_m[i*W +: W]  = W'($urandom);
          left_m[i*W +: W] = W'($urandom);
        end
        repeat (2) @(negedge clk);
      end else begin
        stw = ~(16'($urandom) & 16'($urandom) & 16'($urandom));
        repeat ($urandom_range(1, 14)) @(negedge clk);
      end
    end
    stw = '1;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
